// File: rtl/param_mdu.sv
// param_mdu: iterative multiply/divide unit for the RISC-V M-extension operations
module param_mdu #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [2:0]      operation_i,
    input  logic [XLEN-1:0] MDU_in_X_i,
    input  logic [XLEN-1:0] MDU_in_Y_i,
    output logic [XLEN-1:0] MDU_out_o,
    output logic            done_o,
    output logic            busy_o
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] x_q, y_q, quo_q, rem_q, dvs_q;
    logic            qneg_q, rneg_q;

    logic            in_sx, in_sy, div_zero, div_ovf, mul_xs, mul_ys;
    logic [XLEN-1:0] abs_x, abs_y, mul_res, fix_res, quo_d, rem_d;
    logic [2*XLEN-1:0] pa, pb, prod;
    logic [XLEN:0]   shifted, diff;

    // Request decode: signed divides work on magnitudes, with zero-divisor and overflow early-outs
    always_comb begin
        in_sx    = !operation_i[0] && MDU_in_X_i[XLEN-1];
        in_sy    = !operation_i[0] && MDU_in_Y_i[XLEN-1];
        abs_x    = in_sx ? -MDU_in_X_i : MDU_in_X_i;
        abs_y    = in_sy ? -MDU_in_Y_i : MDU_in_Y_i;
        div_zero = MDU_in_Y_i == '0;
        div_ovf  = !operation_i[0] && MDU_in_X_i == MIN_NEG && MDU_in_Y_i == '1;
    end

    // Full-width product of the latched operands; extension choice selects signed/unsigned halves
    always_comb begin
        mul_xs  = op_q == 3'b001 || op_q == 3'b010;
        mul_ys  = op_q == 3'b001;
        pa      = {{XLEN{mul_xs & x_q[XLEN-1]}}, x_q};
        pb      = {{XLEN{mul_ys & y_q[XLEN-1]}}, y_q};
        prod    = pa * pb;
        mul_res = op_q == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // One restoring-division step, plus the final sign fix-up of quotient or remainder
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
        fix_res = op_q[1] ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);
    end

    // Control FSM with registered result, done pulse and busy flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            MDU_out_o <= '0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                busy_o  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        op_q   <= operation_i;
                        x_q    <= MDU_in_X_i;
                        y_q    <= MDU_in_Y_i;
                        cnt_q  <= '0;
                        busy_o <= 1'b1;
                        if (!operation_i[2]) begin
                            state_q <= MUL;
                        end else if (div_zero) begin
                            quo_q   <= '1;
                            rem_q   <= MDU_in_X_i;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= FIX;
                        end else if (div_ovf) begin
                            quo_q   <= MDU_in_X_i;
                            rem_q   <= '0;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= FIX;
                        end else begin
                            quo_q   <= abs_x;
                            rem_q   <= '0;
                            dvs_q   <= abs_y;
                            qneg_q  <= in_sx ^ in_sy;
                            rneg_q  <= in_sx;
                            state_q <= DIV;
                        end
                    end
                    MUL: if (cnt_q == CW'(MUL_LAT - 1)) begin
                        MDU_out_o <= mul_res;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    DIV: begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN - 1)) state_q <= FIX;
                    end
                    FIX: begin
                        MDU_out_o <= fix_res;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_param_mdu.sv
// tb_param_mdu: scoreboard bench for param_mdu at 32-bit/latency-2 and 16-bit/latency-1
module tb_param_mdu;
    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    typedef struct {
        logic [31:0] v;
        int          c;
        string       n;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [2:0]  op1 = '0, op2 = '0;
    logic [31:0] x1 = '0, y1 = '0, out1;
    logic [15:0] x2 = '0, y2 = '0, out2;
    logic        done1, busy1, done2, busy2;
    int          cyc = 0, total = 0, passed = 0;
    exp_t        q1[$], q2[$];

    param_mdu #(.XLEN(32), .MUL_LAT(2)) dut32 (
        .clk_i(clk), .reset_i(rst), .start_i(start1), .abort_i(abort1), .operation_i(op1),
        .MDU_in_X_i(x1), .MDU_in_Y_i(y1), .MDU_out_o(out1), .done_o(done1), .busy_o(busy1));

    param_mdu #(.XLEN(16), .MUL_LAT(1)) dut16 (
        .clk_i(clk), .reset_i(rst), .start_i(start2), .abort_i(abort2), .operation_i(op2),
        .MDU_in_X_i(x2), .MDU_in_Y_i(y2), .MDU_out_o(out2), .done_o(done2), .busy_o(busy2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Monitor: every done pulse is matched against the oldest expected result and its completion cycle
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL dut32_unexpected_done: got out=%0h, required no done", out1);
            end else begin
                e = q1.pop_front();
                chk({e.n, "_value"}, 64'(out1), 64'(e.v));
                chk({e.n, "_cycle"}, 64'(cyc), 64'(e.c));
            end
        end
        if (done2) begin
            if (q2.size() == 0) begin
                total++;
                $display("FAIL dut16_unexpected_done: got out=%0h, required no done", out2);
            end else begin
                e = q2.pop_front();
                chk({e.n, "_value"}, 64'(out2), 64'(e.v));
                chk({e.n, "_cycle"}, 64'(cyc), 64'(e.c));
            end
        end
    end

    // Called at a negedge: start is sampled on the next edge E0; inputs are scrambled right after
    task automatic issue(input bit d, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ev, input int lat, input bit push, input string n);
        exp_t e;
        if (!d) begin
            start1 = 1'b1; op1 = op; x1 = x; y1 = y;
        end else begin
            start2 = 1'b1; op2 = op; x2 = x[15:0]; y2 = y[15:0];
        end
        if (push) begin
            e.v = ev; e.c = cyc + 1 + lat; e.n = n;
            if (!d) q1.push_back(e);
            else q2.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        op1 = 3'($urandom); x1 = $urandom; y1 = $urandom;
        op2 = 3'($urandom); x2 = 16'($urandom); y2 = 16'($urandom);
    endtask

    task automatic wait_done(input bit d);
        int n = 0;
        while ((d ? q2.size() : q1.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            $display("FAIL timeout_dut%0d: got %0d pending results, required 0", d ? 16 : 32, d ? q2.size() : q1.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_out32", 64'(out1), 64'h0);
        chk("reset_done32", 64'(done1), 64'h0);
        chk("reset_busy32", 64'(busy1), 64'h0);
        chk("reset_out16", 64'(out2), 64'h0);
        rst = 1'b0;
        issue(0, OP_MUL, 32'd5, 32'd3, 32'h0000000F, 2, 1, "mul_5x3");
        chk("mul_busy_e0", 64'(busy1), 64'h1);
        @(negedge clk);
        chk("mul_busy_e1", 64'(busy1), 64'h1);
        @(negedge clk);
        chk("mul_busy_e2", 64'(busy1), 64'h0);
        chk("mul_done_e2", 64'(done1), 64'h1);
        wait_done(0);

        issue(1, OP_MULHU, 32'hFFFF, 32'hFFFF, 32'hFFFE, 1, 1, "mulhu16"); wait_done(1);
        issue(1, OP_MUL, 32'hFFFF, 32'hFFFF, 32'h0001, 1, 1, "mul16"); wait_done(1);
        issue(1, OP_MULH, 32'h8000, 32'h8000, 32'h4000, 1, 1, "mulh16"); wait_done(1);
        issue(1, OP_DIVU, 32'd100, 32'd7, 32'd14, 17, 1, "divu16"); wait_done(1);
        issue(1, OP_REMU, 32'd100, 32'd7, 32'd2, 17, 1, "remu16"); wait_done(1);
        issue(1, OP_DIV, 32'hFF9C, 32'd7, 32'hFFF2, 17, 1, "div16_neg"); wait_done(1);

        issue(0, OP_MULH, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 2, 1, "mulh_neg"); wait_done(0);
        issue(0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1, "mulhu_max"); wait_done(0);
        issue(0, OP_MULHSU, 32'hFFFFFFA0, 32'h1FFFFFFC, 32'hFFFFFFF4, 2, 1, "mulhsu"); wait_done(0);
        issue(0, OP_DIV, 32'hFFFFFFA0, 32'h1FFFFFFC, 32'h00000000, 33, 1, "div_small"); wait_done(0);
        issue(0, OP_REM, 32'hFFFFFFA0, 32'h1FFFFFFC, 32'hFFFFFFA0, 33, 1, "rem_small"); wait_done(0);
        issue(0, OP_DIVU, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1, 1, "divu_by0"); wait_done(0);
        issue(0, OP_DIV, 32'd9, 32'd0, 32'hFFFFFFFF, 1, 1, "div_by0"); wait_done(0);
        issue(0, OP_REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, 1, "rem_by0"); wait_done(0);
        issue(0, OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1, "rem_ovf"); wait_done(0);
        issue(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, "div_ovf"); wait_done(0);
        issue(0, OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1, "div_m7_2"); wait_done(0);
        issue(0, OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1, "rem_m7_2"); wait_done(0);
        issue(0, OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1, "div_7_m2"); wait_done(0);
        issue(0, OP_REM, 32'd7, 32'hFFFFFFFE, 32'h00000001, 33, 1, "rem_7_m2"); wait_done(0);

        issue(0, OP_DIV, 32'd15, 32'd3, 32'd5, 33, 1, "div_15_3");
        repeat (5) @(negedge clk);
        start1 = 1'b1; op1 = OP_MUL;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(0);
        issue(0, OP_REMU, 32'd15, 32'd4, 32'd3, 33, 1, "remu_15_4"); wait_done(0);

        issue(0, OP_MUL, 32'd7, 32'd6, 32'd42, 2, 1, "mul_b2b_a");
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done", 64'(done1), 64'h1);
        issue(0, OP_MUL, 32'd100, 32'd100, 32'h00002710, 2, 1, "mul_b2b_b");
        wait_done(0);

        issue(0, OP_MUL, 32'd9, 32'd9, 32'd0, 2, 0, "mul_abort");
        @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_at_done_done", 64'(done1), 64'h0);
        chk("abort_at_done_busy", 64'(busy1), 64'h0);
        chk("abort_at_done_out", 64'(out1), 64'h2710);
        repeat (5) @(negedge clk);

        issue(0, OP_DIV, 32'd1000, 32'd7, 32'd0, 33, 0, "div_abort");
        repeat (10) @(negedge clk);
        chk("abort_div_busy_before", 64'(busy1), 64'h1);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_div_busy", 64'(busy1), 64'h0);
        chk("abort_div_done", 64'(done1), 64'h0);
        chk("abort_div_out", 64'(out1), 64'h2710);
        repeat (40) @(negedge clk);
        chk("abort_div_out_held", 64'(out1), 64'h2710);

        issue(0, OP_DIV, 32'd1000, 32'd7, 32'd0, 33, 0, "div_reset");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_out", 64'(out1), 64'h0);
        chk("midreset_busy", 64'(busy1), 64'h0);
        chk("midreset_done", 64'(done1), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        issue(0, OP_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 2, 1, "mul_post_reset");
        wait_done(0);
        repeat (40) @(negedge clk);

        chk("q32_empty", 64'(q1.size()), 64'h0);
        chk("q16_empty", 64'(q2.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/param_mdu.md
PARAM_MDU -- requirements
Module: param_mdu

Interface
REQ-001 Parameter XLEN, 32, operand/result width; legal values 8..64.
REQ-002 Parameter MUL_LAT, 2, multiply latency in cycles; legal values 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request strobe; sampled only while busy=0.
REQ-006 abort  input  1  synchronous cancel of the in-flight operation.
REQ-007 operation  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 MDU_in_X  input  XLEN  rs1 operand; dividend/multiplicand.
REQ-009 MDU_in_Y  input  XLEN  rs2 operand; divisor/multiplier.
REQ-010 MDU_out  output  XLEN  result; valid when done=1; held until next done.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high from the edge accepting start until the edge asserting done, or until abort takes effect.

Function
REQ-013 FSM states: IDLE, MUL, DIV, FIX; IDLE->MUL or DIV on accepted start; MUL->IDLE after MUL_LAT cycles; DIV->FIX after XLEN iterations; FIX->IDLE after one cycle.
REQ-014 On accepting start, operation, MDU_in_X and MDU_in_Y are latched; later input changes do not affect the result.
REQ-015 start while busy=1 is ignored: no queuing, no restart.
REQ-016 Multiply: start accepted at edge E0 -> done=1 and MDU_out valid after edge E0+MUL_LAT.
REQ-017 MUL returns low XLEN bits of the product; MULH returns high XLEN bits of signed*signed; MULHSU returns high bits of signed X * unsigned Y; MULHU returns high bits of unsigned*unsigned.
REQ-018 Divide: restoring, one quotient bit per cycle, on magnitudes; sign fix-up in FIX; done after edge E0+XLEN+1.
REQ-019 Signed quotient is truncated toward zero; signed remainder takes the sign of the dividend.
REQ-020 Divide by zero (Y=0), early-out: quotient all ones, remainder = X; done after edge E0+1; DIV and DIVU alike.
REQ-021 Signed overflow (DIV/REM, X = most negative value, Y = all ones), early-out: quotient = X, remainder = 0; done after edge E0+1.
REQ-022 done is high for exactly one cycle per completed operation; busy falls on the same edge that raises done.
REQ-023 start accepted while done=1 in the same cycle is legal; next operation begins with no idle cycle.
REQ-024 abort=1 with busy=1: FSM returns to IDLE on the next edge, busy falls, done is not raised, MDU_out keeps its prior value.
REQ-025 abort and start high together with busy=0: abort wins; start is not accepted.
REQ-026 abort in the cycle done would rise: done is suppressed and MDU_out is not updated.

Reset
REQ-027 reset=1 immediately forces state IDLE, MDU_out=0, done=0, busy=0, and clears internal accumulators, independent of clk.
REQ-028 reset asserted mid-operation discards that operation; no done pulse follows deassertion.
REQ-029 First start is accepted on the first rising edge after reset deasserts.

Verification
REQ-030 XLEN=32, MUL, X=5, Y=3 -> MDU_out=0x0000000F with done after E0+2; busy high for 2 cycles.
REQ-031 MULHSU, X=-0x60, Y=0x1FFFFFFC -> 0xFFFFFFF4; DIV with same operands -> 0x00000000; REM with same operands -> 0xFFFFFFA0.
REQ-032 DIVU, X=0xFFFFFFFF, Y=0 -> 0xFFFFFFFF after E0+1; REM, X=0x80000000, Y=0xFFFFFFFF -> 0x00000000 after E0+1.
REQ-033 DIV, X=15, Y=3 -> 5 with done after E0+33; REMU, X=15, Y=4 -> 3; start pulsed mid-divide is ignored.
REQ-034 DIV started, abort at E0+10 -> busy=0 at E0+11, no done, MDU_out unchanged; reset at E0+5 of a new divide -> outputs 0 immediately.
REQ-035 XLEN=16, MUL_LAT=1, MULHU, X=0xFFFF, Y=0xFFFF -> 0xFFFE after E0+1; MUL on same operands -> 0x0001.
